// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter
//   Round-robin, burst-oriented arbiter that places one of NUM_SRC sources
//   onto a shared registered WIDTH-bit bus. A grant is held until the owner
//   marks its last beat or MAX_BURST beats have been accepted. Every release
//   passes through one IDLE arbitration cycle.
//
// Ports
//   i_clk        system clock (rising edge)
//   i_rst_n      asynchronous active-low reset
//   i_req        per-source request / per-beat valid while granted
//   i_last       per-source end-of-burst marker (qualified by owner's req)
//   i_data_in    per-source data, packed [NUM_SRC-1:0][WIDTH-1:0]
//   i_stall      downstream back-pressure; bus outputs hold
//   o_gnt        registered one-hot grant, zero when idle
//   o_bus_out    registered bus data
//   o_bus_valid  o_bus_out carries an accepted beat
//   o_bus_src    index of the source that produced o_bus_out
module shared_bus_arbiter #(
  parameter int WIDTH     = 12,
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_SRC-1:0]                i_req,
  input  logic [NUM_SRC-1:0]                i_last,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]     i_data_in,
  input  logic                              i_stall,
  output logic [NUM_SRC-1:0]                o_gnt,
  output logic [WIDTH-1:0]                  o_bus_out,
  output logic                              o_bus_valid,
  output logic [$clog2(NUM_SRC)-1:0]        o_bus_src
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [SRC_W:0]   NUM_SRC_EXT = (SRC_W + 1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] CNT_CAP     = CNT_W'(MAX_BURST);
  localparam logic [SRC_W-1:0] SRC_LAST    = SRC_W'(NUM_SRC - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                 r_state, w_state_next;
  logic [SRC_W-1:0]       r_owner, w_owner_next;
  logic [SRC_W-1:0]       r_ptr, w_ptr_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic [NUM_SRC-1:0]     r_gnt, w_gnt_next;
  logic [WIDTH-1:0]       r_bus_out, w_bus_out_next;
  logic                   r_bus_valid, w_bus_valid_next;
  logic [SRC_W-1:0]       r_bus_src, w_bus_src_next;

  // Arbitration: rotate requests so bit 0 corresponds to r_ptr, find the
  // first set bit, then map the offset back to an absolute index.
  logic [2*NUM_SRC-1:0]   w_req_dbl;
  logic [NUM_SRC-1:0]     w_req_rot;
  logic [SRC_W-1:0]       w_offset;
  logic [SRC_W:0]         w_sum;
  logic [SRC_W-1:0]       w_winner;
  logic [NUM_SRC-1:0]     w_winner_onehot;

  assign w_req_dbl = {i_req, i_req} >> r_ptr;
  assign w_req_rot = w_req_dbl[NUM_SRC-1:0];

  always_comb begin
    w_offset = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_offset = SRC_W'(k);
    end
  end

  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_offset};
  assign w_winner = (w_sum >= NUM_SRC_EXT) ? SRC_W'(w_sum - NUM_SRC_EXT)
                                           : w_sum[SRC_W-1:0];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
    assign w_winner_onehot[gi] = (w_winner == SRC_W'(gi));
  end

  // Owner-side view of the inputs.
  logic             w_owner_req;
  logic             w_owner_last;
  logic [WIDTH-1:0] w_owner_data;
  logic             w_accept;
  logic             w_release;
  logic [SRC_W-1:0] w_owner_inc;

  assign w_owner_req  = i_req[r_owner];
  assign w_owner_last = i_last[r_owner];
  assign w_owner_data = i_data_in[r_owner];
  assign w_accept     = (r_state == S_BUSY) && w_owner_req && !i_stall;
  // The cap counts accepted beats including the one on this edge.
  assign w_release    = w_accept && (w_owner_last || ((r_cnt + 1'b1) == CNT_CAP));
  assign w_owner_inc  = (r_owner == SRC_LAST) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_ptr_next       = r_ptr;
    w_cnt_next       = r_cnt;
    w_gnt_next       = r_gnt;
    w_bus_out_next   = r_bus_out;
    w_bus_valid_next = r_bus_valid;
    w_bus_src_next   = r_bus_src;
    case (r_state)
      S_IDLE: begin
        if (!i_stall) w_bus_valid_next = 1'b0;
        // Arbitration ignores stall; only the bus side is held.
        if (|i_req) begin
          w_state_next = S_BUSY;
          w_owner_next = w_winner;
          w_gnt_next   = w_winner_onehot;
          w_cnt_next   = '0;
        end
      end
      S_BUSY: begin
        if (w_accept) begin
          w_bus_out_next   = w_owner_data;
          w_bus_valid_next = 1'b1;
          w_bus_src_next   = r_owner;
          w_cnt_next       = r_cnt + 1'b1;
          if (w_release) begin
            w_state_next = S_IDLE;
            w_gnt_next   = '0;
            w_ptr_next   = w_owner_inc;
            w_cnt_next   = '0;
          end
        end else if (!i_stall) begin
          // Bubble: owner keeps the grant but sends nothing this cycle.
          w_bus_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
      r_bus_src   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_ptr       <= w_ptr_next;
      r_cnt       <= w_cnt_next;
      r_gnt       <= w_gnt_next;
      r_bus_out   <= w_bus_out_next;
      r_bus_valid <= w_bus_valid_next;
      r_bus_src   <= w_bus_src_next;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_bus_out   = r_bus_out;
  assign o_bus_valid = r_bus_valid;
  assign o_bus_src   = r_bus_src;

endmodule
